serial_code_lock: RTL and testbench
===================================

SERIAL_CODE_LOCK -- requirements
Module: serial_code_lock

Interface
REQ-001 SHALL have parameter CODE_LEN, default 8: number of code bits per attempt, legal range 2..32.
REQ-002 SHALL have parameter CODE, default 8'b0101_0100, width CODE_LEN: the unlock code, MSB received first.
REQ-003 SHALL have parameter MAX_TRIES, default 3: consecutive failed attempts before lockout, legal range 1..15.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 16: lockout duration in clk cycles, legal range 1..2^16-1; used only when LOCK_TIMEOUT_EN is defined.
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port x, input, 1 bit: serial code bit.
REQ-008 SHALL have port x_valid, input, 1 bit: x is sampled on a rising clk edge only while x_valid=1.
REQ-009 SHALL have port clear, input, 1 bit: synchronous re-arm command.
REQ-010 SHALL have port y, output, 1 bit: registered unlock level.
REQ-011 SHALL have port fail, output, 1 bit: one-cycle pulse per failed attempt.
REQ-012 SHALL have port locked_out, output, 1 bit: high while in LOCKOUT.
REQ-013 SHALL have port fail_cnt, output, $clog2(MAX_TRIES+1) bits: consecutive-failure count.

Function
REQ-014 SHALL implement a state machine with states IDLE, COLLECT, OPEN and LOCKOUT.
REQ-015 SHALL, in IDLE, on x_valid=1: shift x into the code register, set the bit counter to 1, and go to COLLECT.
REQ-016 SHALL, in COLLECT, shift x on each x_valid=1 and increment the bit counter; cycles with x_valid=0 hold all state, with no timeout.
REQ-017 SHALL compare the code register against CODE on the edge that samples bit CODE_LEN, using the full CODE_LEN-bit value with that bit included.
REQ-018 SHALL, on a match: go to OPEN, set y=1 and clear fail_cnt to 0, all on that same edge.
REQ-019 SHALL, on a mismatch: pulse fail=1 for one cycle and increment fail_cnt; go to LOCKOUT if the new fail_cnt equals MAX_TRIES, otherwise go to IDLE.
REQ-020 SHALL give a latency of 1 edge: y, fail and locked_out reflect an attempt's result in the cycle immediately after the final bit is sampled.
REQ-021 SHALL, in OPEN, hold y=1 and ignore x_valid; clear=1 returns the block to IDLE with y=0.
REQ-022 SHALL, in LOCKOUT, hold locked_out=1 and y=0, ignore x_valid and clear, and hold fail_cnt at MAX_TRIES.
REQ-023 SHALL, on clear=1 in IDLE or COLLECT, discard any partial attempt, reset the bit counter, and go to IDLE; fail_cnt is unchanged.
REQ-024 SHALL give clear priority over x_valid when both are asserted in the same cycle, so that bit is discarded.
REQ-025 SHALL saturate fail_cnt at MAX_TRIES and never wrap.
REQ-026 SHALL never assert y and locked_out together, and SHALL never assert y and fail together.
REQ-027 SHALL map any illegal state encoding to IDLE with all outputs 0 on the next edge.

Reset
REQ-028 SHALL, on reset=1 and independent of clk, force: state=IDLE, y=0, fail=0, locked_out=0, fail_cnt=0, bit counter=0, code register=0, lockout timer=0.
REQ-029 SHALL abort any operation in progress on reset, including COLLECT, OPEN and LOCKOUT, with no residual effect once reset is released.

Configuration
REQ-030 SHALL use macro LOCK_TIMEOUT_EN to control lockout exit.
REQ-031 SHALL, with LOCK_TIMEOUT_EN defined: load a down-counter with LOCKOUT_CYCLES on LOCKOUT entry, and exit to IDLE with fail_cnt=0 and locked_out=0 on the edge where the counter reaches 0, so locked_out is high for exactly LOCKOUT_CYCLES cycles.
REQ-032 SHALL, with LOCK_TIMEOUT_EN undefined: make LOCKOUT terminal until reset, and synthesize no timer logic.

Verification (CODE_LEN=8, CODE=8'h54, MAX_TRIES=3, LOCKOUT_CYCLES=16)
REQ-033 SHALL cover: bits 0,1,0,1,0,1,0,0 on consecutive x_valid cycles -> y=1 the cycle after bit 8, fail_cnt=0; then clear -> y=0 and state IDLE.
REQ-034 SHALL cover: 8'h55, then 8'h54 -> fail pulse once and fail_cnt=1 after the first attempt; y=1 and fail_cnt=0 after the second.
REQ-035 SHALL cover: three attempts of 8'hFF -> fail pulses 3 times and locked_out=1 after the third; further 8'h54 input and clear leave y=0.
REQ-036 SHALL cover: with LOCK_TIMEOUT_EN, the same scenario as REQ-035 -> locked_out high for exactly 16 cycles, then 8'h54 gives y=1; without LOCK_TIMEOUT_EN, locked_out stays 1 for 1000 cycles.
REQ-037 SHALL cover: 5 bits of 8'h54 followed by clear with x_valid=1 in the same cycle, then the full 8'h54 -> y=1 only after the full 8 bits; the first 5 bits have no effect.
REQ-038 SHALL cover: reset asserted mid-COLLECT and mid-OPEN, asynchronously between clk edges -> all outputs 0 immediately; the next 8'h54 gives y=1.

Source files
------------

// File: rtl/serial_code_lock.sv
// Bit-serial code lock: MSB-first entry, consecutive-failure counting and lockout.
// Define LOCK_TIMEOUT_EN for a LOCKOUT that expires after LOCKOUT_CYCLES; otherwise LOCKOUT holds until reset.
module serial_code_lock #(
    parameter int unsigned         CODE_LEN       = 8,
    parameter logic [CODE_LEN-1:0] CODE           = 8'b0101_0100,
    parameter int unsigned         MAX_TRIES      = 3,
    parameter int unsigned         LOCKOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           x,
    input  logic                           x_valid,
    input  logic                           clear,
    output logic                           y,
    output logic                           fail,
    output logic                           locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt
);
    localparam int unsigned CW = $clog2(MAX_TRIES + 1);
    localparam int unsigned BW = $clog2(CODE_LEN + 1);

    if (CODE_LEN < 2 || CODE_LEN > 32) begin : g_bad_code_len
        $error("serial_code_lock: CODE_LEN must be 2..32");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
        $error("serial_code_lock: MAX_TRIES must be 1..15");
    end
    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535) begin : g_bad_lockout
        $error("serial_code_lock: LOCKOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        OPEN,
        LOCKOUT
    } state_t;

    state_t              state_q;
    // Only CODE_LEN-1 bits of history are kept; the final bit is compared straight from x.
    logic [CODE_LEN-2:0] code_q;
    logic [CODE_LEN-1:0] code_d;
    logic [BW-1:0]       bit_cnt_q;
    logic [CW-1:0]       fail_cnt_q;
    logic [CW-1:0]       fail_cnt_d;
    logic                y_q;
    logic                fail_q;
    logic                locked_out_q;
`ifdef LOCK_TIMEOUT_EN
    logic [15:0]         timer_q;
`endif

    assign code_d     = {code_q, x};
    assign fail_cnt_d = (fail_cnt_q == CW'(MAX_TRIES)) ? fail_cnt_q : fail_cnt_q + CW'(1);

    assign y          = y_q;
    assign fail       = fail_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            code_q       <= '0;
            bit_cnt_q    <= '0;
            fail_cnt_q   <= '0;
            y_q          <= 1'b0;
            fail_q       <= 1'b0;
            locked_out_q <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        bit_cnt_q <= '0;
                    end else if (x_valid) begin
                        code_q    <= code_d[CODE_LEN-2:0];
                        bit_cnt_q <= BW'(1);
                        state_q   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (clear) begin
                        bit_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else if (x_valid) begin
                        code_q <= code_d[CODE_LEN-2:0];
                        if (bit_cnt_q == BW'(CODE_LEN - 1)) begin
                            bit_cnt_q <= '0;
                            if (code_d == CODE) begin
                                state_q    <= OPEN;
                                y_q        <= 1'b1;
                                fail_cnt_q <= '0;
                            end else begin
                                fail_q     <= 1'b1;
                                fail_cnt_q <= fail_cnt_d;
                                if (fail_cnt_d == CW'(MAX_TRIES)) begin
                                    state_q      <= LOCKOUT;
                                    locked_out_q <= 1'b1;
`ifdef LOCK_TIMEOUT_EN
                                    timer_q      <= 16'(LOCKOUT_CYCLES);
`endif
                                end else begin
                                    state_q <= IDLE;
                                end
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                OPEN: begin
                    if (clear) begin
                        state_q <= IDLE;
                        y_q     <= 1'b0;
                    end
                end
                LOCKOUT: begin
`ifdef LOCK_TIMEOUT_EN
                    // Exit on the edge the timer hits zero, so locked_out spans LOCKOUT_CYCLES cycles.
                    if (timer_q == 16'd1) begin
                        timer_q      <= '0;
                        state_q      <= IDLE;
                        locked_out_q <= 1'b0;
                        fail_cnt_q   <= '0;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
`endif
                end
                default: begin
                    state_q      <= IDLE;
                    bit_cnt_q    <= '0;
                    fail_cnt_q   <= '0;
                    y_q          <= 1'b0;
                    locked_out_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_code_lock.sv
// Scoreboard bench for serial_code_lock: the driver queues the expected outputs for each cycle,
// a monitor pops and compares them one time unit after each clock edge or asynchronous reset.
module tb_serial_code_lock;
    typedef struct packed {
        logic       y;
        logic       fail;
        logic       lo;
        logic [1:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rst_next;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       clear = 1'b0;
    logic       y;
    logic       fail;
    logic       locked_out;
    logic [1:0] fail_cnt;

    exp_t exp_q[$];
    event async_ev;
    int   checks = 0;
    int   errors = 0;

    serial_code_lock #(
        .CODE_LEN       (8),
        .CODE           (8'h54),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .x_valid    (x_valid),
        .clear      (clear),
        .y          (y),
        .fail       (fail),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t ex(input logic yy, input logic ff, input logic ll, input logic [1:0] cc);
        return {yy, ff, ll, cc};
    endfunction

    // Monitor: one expectation per clock cycle, plus one per asynchronous reset event.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {y, fail, locked_out, fail_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got y=%b fail=%b lo=%b cnt=%0d, want y=%b fail=%b lo=%b cnt=%0d",
                             $time, a.y, a.fail, a.lo, a.cnt, e.y, e.fail, e.lo, e.cnt);
                end
                checks++;
                if ((y && locked_out) || (y && fail)) begin
                    errors++;
                    $display("FAIL exclusivity @%0t: got y=%b fail=%b lo=%b, want y never with fail/lo",
                             $time, y, fail, locked_out);
                end
            end
        end
    end

    task automatic cyc(input logic xb, input logic xv, input logic clr, input exp_t e);
        @(negedge clk);
        reset   = rst_next;
        x       = xb;
        x_valid = xv;
        clear   = clr;
        exp_q.push_back(e);
    endtask

    task automatic bits(input logic [7:0] c, input int n, input bit gap, input exp_t hold, input exp_t last);
        for (int i = 0; i < n; i++) begin
            cyc(c[7-i], 1'b1, 1'b0, (i == n - 1) ? last : hold);
            if (gap && i != n - 1) cyc(~c[7-i], 1'b0, 1'b0, hold);
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset    = 1'b1;
        rst_next = 1'b1;
        exp_q.push_back(ex(0, 0, 0, 2'd0));
        ->async_ev;
    endtask

    initial begin
        logic [7:0] k;
        k        = 8'h54;
        reset    = 1'b1;
        rst_next = 1'b1;
        cyc(0, 0, 0, ex(0, 0, 0, 0));
        cyc(0, 1, 0, ex(0, 0, 0, 0));
        rst_next = 1'b0;
        cyc(0, 0, 0, ex(0, 0, 0, 0));

        // correct code, OPEN ignores x_valid, clear re-arms
        bits(8'h54, 8, 0, ex(0, 0, 0, 0), ex(1, 0, 0, 0));
        cyc(1, 1, 0, ex(1, 0, 0, 0));
        cyc(0, 1, 0, ex(1, 0, 0, 0));
        cyc(0, 0, 1, ex(0, 0, 0, 0));
        cyc(0, 0, 0, ex(0, 0, 0, 0));

        // wrong code entered with x_valid gaps, then right code
        bits(8'h55, 8, 1, ex(0, 0, 0, 0), ex(0, 1, 0, 1));
        cyc(0, 0, 0, ex(0, 0, 0, 1));
        bits(8'h54, 8, 0, ex(0, 0, 0, 1), ex(1, 0, 0, 0));
        cyc(0, 0, 1, ex(0, 0, 0, 0));

        // partial attempt discarded by clear (with x_valid), fail_cnt kept
        bits(8'hFF, 8, 0, ex(0, 0, 0, 0), ex(0, 1, 0, 1));
        cyc(0, 0, 0, ex(0, 0, 0, 1));
        bits(8'h54, 5, 0, ex(0, 0, 0, 1), ex(0, 0, 0, 1));
        cyc(1, 1, 1, ex(0, 0, 0, 1));
        bits(8'h54, 8, 0, ex(0, 0, 0, 1), ex(1, 0, 0, 0));
        cyc(0, 0, 1, ex(0, 0, 0, 0));

        // three failures -> lockout; code and clear ignored
        bits(8'hFF, 8, 0, ex(0, 0, 0, 0), ex(0, 1, 0, 1));
        cyc(0, 0, 0, ex(0, 0, 0, 1));
        bits(8'hFF, 8, 0, ex(0, 0, 0, 1), ex(0, 1, 0, 2));
        cyc(0, 0, 0, ex(0, 0, 0, 2));
        bits(8'hFF, 8, 0, ex(0, 0, 0, 2), ex(0, 1, 1, 3));
        for (int i = 0; i < 15; i++) cyc(k[7 - (i % 8)], 1'b1, i >= 8, ex(0, 0, 1, 3));
`ifdef LOCK_TIMEOUT_EN
        cyc(0, 0, 0, ex(0, 0, 0, 0));
        bits(8'h54, 8, 0, ex(0, 0, 0, 0), ex(1, 0, 0, 0));
        cyc(0, 0, 1, ex(0, 0, 0, 0));
`else
        for (int i = 0; i < 1000; i++) cyc((i % 2) == 1, 1'b1, (i % 4) == 3, ex(0, 0, 1, 3));
        async_reset();
        cyc(0, 0, 0, ex(0, 0, 0, 0));
        rst_next = 1'b0;
        cyc(0, 0, 0, ex(0, 0, 0, 0));
`endif

        // async reset mid-COLLECT, then mid-OPEN
        bits(8'h54, 4, 0, ex(0, 0, 0, 0), ex(0, 0, 0, 0));
        async_reset();
        cyc(0, 1, 0, ex(0, 0, 0, 0));
        rst_next = 1'b0;
        cyc(0, 0, 0, ex(0, 0, 0, 0));
        bits(8'h54, 8, 0, ex(0, 0, 0, 0), ex(1, 0, 0, 0));
        cyc(0, 0, 0, ex(1, 0, 0, 0));
        async_reset();
        cyc(0, 0, 0, ex(0, 0, 0, 0));
        rst_next = 1'b0;
        cyc(0, 0, 0, ex(0, 0, 0, 0));
        bits(8'h54, 8, 0, ex(0, 0, 0, 0), ex(1, 0, 0, 0));
        cyc(0, 0, 1, ex(0, 0, 0, 0));
        cyc(0, 0, 0, ex(0, 0, 0, 0));

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unconsumed expectations, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
